// File: rtl/min_max_ctrl_if.sv
// min_max_ctrl_if: edit/mode inputs and datapath-facing outputs of min_max_ctrl.
interface min_max_ctrl_if #(parameter int VALSIZE = 4);
    logic               sel_i, inc_i, dec_i, lin_i;
    logic [1:0]         com_o, field_o;
    logic [VALSIZE-1:0] min_o, max_o, val_o;
    logic               osc_o;
    modport master (output sel_i, inc_i, dec_i, lin_i,
                    input  com_o, field_o, min_o, max_o, val_o, osc_o);
    modport slave  (input  sel_i, inc_i, dec_i, lin_i,
                    output com_o, field_o, min_o, max_o, val_o, osc_o);
endinterface

// File: rtl/min_max_ctrl.sv
// min_max_ctrl: min/max/value editor, blink oscillator and mode driver for min_max_top.
// Optional power-up self-test (all on, then all off) enabled by MIN_MAX_CTRL_SELFTEST_EN.
module min_max_ctrl #(
    parameter int VALSIZE     = 4,
    parameter int OSC_DIV     = 8,
    parameter int TEST_CYCLES = 16
) (
    input logic            clk_i,
    input logic            rst_n_i,
    min_max_ctrl_if.slave  bus
);
    localparam logic [1:0] F_VAL = 2'd0;
    localparam logic [1:0] F_MIN = 2'd1;
    localparam logic [1:0] F_MAX = 2'd2;
    localparam logic [VALSIZE-1:0] ALL1 = '1;
    localparam int OW = $clog2(OSC_DIV + 1);
    localparam logic [OW-1:0] OSC_TC = OW'(OSC_DIV - 1);

    logic               run;
    logic [1:0]         com_q, com_d, field_q, field_d;
    logic [VALSIZE-1:0] min_q, min_d, max_q, max_d, val_q, val_d;
    logic [OW-1:0]      osc_cnt_q, osc_cnt_d;
    logic               osc_q, osc_d;
    logic               inc_ok, dec_ok;

`ifdef MIN_MAX_CTRL_SELFTEST_EN
    localparam logic [1:0] ST_ON  = 2'd0;
    localparam logic [1:0] ST_OFF = 2'd1;
    localparam logic [1:0] RUN    = 2'd2;
    localparam logic [1:0] COM_RST = 2'b11;
    localparam int PW = $clog2(TEST_CYCLES + 1);
    localparam logic [PW-1:0] PH_TC = PW'(TEST_CYCLES - 1);

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        if (state_q != RUN) begin
            phase_d = (phase_q == PH_TC) ? '0 : phase_q + 1'b1;
            state_d = (phase_q != PH_TC) ? state_q : (state_q == ST_ON) ? ST_OFF : RUN;
        end
        com_d = (state_d == ST_ON) ? 2'b11 : (state_d == ST_OFF) ? 2'b10 : {1'b0, bus.lin_i};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_ON;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    assign run = (state_q == RUN);
`else
    localparam logic [1:0] COM_RST = 2'b00;

    assign run   = 1'b1;
    assign com_d = {1'b0, bus.lin_i};
`endif

    // Simultaneous inc and dec cancel out.
    assign inc_ok = run & bus.inc_i & ~bus.dec_i;
    assign dec_ok = run & bus.dec_i & ~bus.inc_i;

    always_comb begin
        val_d = (field_q == F_VAL && inc_ok && val_q != ALL1)  ? val_q + 1'b1 :
                (field_q == F_VAL && dec_ok && val_q != '0)    ? val_q - 1'b1 : val_q;
        min_d = (field_q == F_MIN && inc_ok && min_q != max_q) ? min_q + 1'b1 :
                (field_q == F_MIN && dec_ok && min_q != '0)    ? min_q - 1'b1 : min_q;
        max_d = (field_q == F_MAX && inc_ok && max_q != ALL1)  ? max_q + 1'b1 :
                (field_q == F_MAX && dec_ok && max_q != min_q) ? max_q - 1'b1 : max_q;
        field_d   = !(run && bus.sel_i) ? field_q : (field_q == F_MAX) ? F_VAL : field_q + 2'd1;
        osc_cnt_d = (osc_cnt_q == OSC_TC) ? '0 : osc_cnt_q + 1'b1;
        osc_d     = (osc_cnt_q == OSC_TC) ? ~osc_q : osc_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            com_q     <= COM_RST;
            field_q   <= F_VAL;
            min_q     <= '0;
            max_q     <= ALL1;
            val_q     <= '0;
            osc_cnt_q <= '0;
            osc_q     <= 1'b0;
        end else begin
            com_q     <= com_d;
            field_q   <= field_d;
            min_q     <= min_d;
            max_q     <= max_d;
            val_q     <= val_d;
            osc_cnt_q <= osc_cnt_d;
            osc_q     <= osc_d;
        end
    end

    assign bus.com_o   = com_q;
    assign bus.field_o = field_q;
    assign bus.min_o   = min_q;
    assign bus.max_o   = max_q;
    assign bus.val_o   = val_q;
    assign bus.osc_o   = osc_q;
endmodule

// File: tb/tb_min_max_ctrl.sv
// tb_min_max_ctrl: directed bench for min_max_ctrl with a snapshot scoreboard.
module tb_min_max_ctrl;
    localparam int VALSIZE = 4;
    localparam int OSC_DIV = 4;
    localparam int TC      = 3;
    localparam int MAXV    = 2**VALSIZE - 1;
`ifdef MIN_MAX_CTRL_SELFTEST_EN
    localparam int ST = TC;
`else
    localparam int ST = 0;
`endif

    typedef struct {
        string      tag;
        logic [1:0] com;
        logic [3:0] mn, mx, vl;
        logic [1:0] fld;
        logic       osc;
    } snap_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    int    vectors = 0;
    int    miscompares = 0;
    int    n = 0;
    int    m_min = 0, m_max = MAXV, m_val = 0, m_fld = 0;
    snap_t sbq[$];

    always #5 clk = ~clk;

    min_max_ctrl_if #(.VALSIZE(VALSIZE)) bus ();

    min_max_ctrl #(.VALSIZE(VALSIZE), .OSC_DIV(OSC_DIV), .TEST_CYCLES(TC)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus.slave)
    );

    task automatic chk(input string tag, input string f, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s.%s observed=%0d expected=%0d", tag, f, obs, exp);
        end
    endtask

    // One clock: drive inputs, push the expected post-edge snapshot, then compare.
    task automatic cyc(input logic r, input logic s, input logic i, input logic d, input logic l, input string tag);
        snap_t e;
        bit    run;
        rst_n = r; bus.sel_i = s; bus.inc_i = i; bus.dec_i = d; bus.lin_i = l;
        if (!r) begin
            m_min = 0; m_max = MAXV; m_val = 0; m_fld = 0; n = 0;
            e.com = (ST > 0) ? 2'b11 : 2'b00;
        end else begin
            run = (n >= 2*ST);
            if (run && !(i && d)) begin
                if (m_fld == 0) begin
                    if (i && m_val < MAXV) m_val++;
                    if (d && m_val > 0) m_val--;
                end else if (m_fld == 1) begin
                    if (i && m_min < m_max) m_min++;
                    if (d && m_min > 0) m_min--;
                end else begin
                    if (i && m_max < MAXV) m_max++;
                    if (d && m_max > m_min) m_max--;
                end
            end
            if (run && s) m_fld = (m_fld == 2) ? 0 : m_fld + 1;
            n++;
            e.com = (n < ST) ? 2'b11 : (n < 2*ST) ? 2'b10 : {1'b0, l};
        end
        e.tag = tag;
        e.mn  = 4'(m_min);
        e.mx  = 4'(m_max);
        e.vl  = 4'(m_val);
        e.fld = 2'(m_fld);
        e.osc = 1'((n / OSC_DIV) % 2);
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk(e.tag, "com",   bus.com_o,   e.com);
        chk(e.tag, "min",   bus.min_o,   e.mn);
        chk(e.tag, "max",   bus.max_o,   e.mx);
        chk(e.tag, "val",   bus.val_o,   e.vl);
        chk(e.tag, "field", bus.field_o, e.fld);
        chk(e.tag, "osc",   bus.osc_o,   e.osc);
    endtask

    initial begin
        bus.sel_i = 1'b0; bus.inc_i = 1'b0; bus.dec_i = 1'b0; bus.lin_i = 1'b0;
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "reset");
        for (int k = 0; k < 2*ST; k++) cyc(1'b1, 1'b0, 1'(k % 2), 1'b0, 1'b0, "selftest");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "run_entry");
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "first_inc");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "val_back0");
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "val_dec_sat0");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "sel_min");
        for (int k = 0; k < 20; k++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "min_inc_clamp");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "sel_max");
        for (int k = 0; k < 20; k++) cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "max_dec_clamp");
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "max_inc_sat");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "sel_val");
        for (int k = 0; k < 18; k++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "val_inc_sat");
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "inc_dec_both");
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "sel_with_dec");
        for (int k = 0; k < 10; k++) cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "min_dec_to5");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "lin_mode");
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "lin_min_inc");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "mid_reset");
        for (int k = 0; k < 2*ST; k++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "selftest2");
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "after_reset_inc");
        for (int k = 0; k < 6; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'(k % 2), "osc_tail");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
